// File: rtl/delay_chain_sequencer.sv
// delay_chain_sequencer
// Sequences an external buffered flop delay chain through clear, launch and
// measure phases, then reports the clock-edge latency from chain input to
// chain output along with pass / timeout / stuck status.
//
// Optional feature macro: DCS_STICKY_FAIL_EN
//   defined   -> fail_sticky accumulates any non-passing run until rst_n
//   undefined -> fail_sticky is tied low and no register is built
//
// chain_clr and chain_din are driven straight from flops whose inputs are
// decoded from the next state, so they change only on clock edges and line
// up exactly with the CLEAR / LAUNCH / MEASURE states.

module delay_chain_sequencer #(
  parameter int DEPTH   = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             chain_clr,
  output logic             chain_din,
  input  logic             chain_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout_err,
  output logic             stuck_err,
  output logic [CNT_W-1:0] latency,
  output logic             fail_sticky
);

  // Depth and timeout expressed at counter width so comparisons match.
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LAUNCH  = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [CNT_W-1:0] latency_q,   latency_d;
  logic             pass_q,      pass_d;
  logic             timeout_q,   timeout_d;
  logic             stuck_q,     stuck_d;
  logic             chainClr_q,  chainClr_d;
  logic             chainDin_q,  chainDin_d;

  // Next-state, counter and result update; the timeout test sits ahead of
  // the increment so the measure counter can never wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latency_d  = latency_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    stuck_d    = stuck_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CLEAR;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          stuck_d   = 1'b0;
          latency_d = '0;
        end
      end

      CLEAR: begin
        state_d = LAUNCH;
      end

      LAUNCH: begin
        if (chain_q) begin
          stuck_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = ONE_C;
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        if (chain_q) begin
          latency_d = cnt_q;
          pass_d    = (cnt_q == DEPTH_C);
          state_d   = DONE;
        end else if (cnt_q == TIMEOUT_C) begin
          timeout_d = 1'b1;
          latency_d = TIMEOUT_C;
          pass_d    = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Chain control decoded from the state being entered, so the registered
  // copies are valid for the whole of that state.
  always_comb begin
    chainClr_d = (state_d == CLEAR);
    chainDin_d = (state_d == LAUNCH) || (state_d == MEASURE);
  end

  // State, counter, results and chain control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      latency_q  <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      stuck_q    <= 1'b0;
      chainClr_q <= 1'b0;
      chainDin_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latency_q  <= latency_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      stuck_q    <= stuck_d;
      chainClr_q <= chainClr_d;
      chainDin_q <= chainDin_d;
    end
  end

`ifdef DCS_STICKY_FAIL_EN
  logic failSticky_q, failSticky_d;

  // Any run that finishes without a pass latches the sticky flag.
  always_comb begin
    failSticky_d = failSticky_q;
    if ((state_q == DONE) && !pass_q) begin
      failSticky_d = 1'b1;
    end
  end

  // Sticky failure register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      failSticky_q <= 1'b0;
    end else begin
      failSticky_q <= failSticky_d;
    end
  end

  assign fail_sticky = failSticky_q;
`else
  assign fail_sticky = 1'b0;
`endif

  assign chain_clr   = chainClr_q;
  assign chain_din   = chainDin_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign pass        = pass_q;
  assign timeout_err = timeout_q;
  assign stuck_err   = stuck_q;
  assign latency     = latency_q;

endmodule

// File: tb/tb_delay_chain_sequencer.sv
// tb_delay_chain_sequencer
// Drives delay_chain_sequencer against a behavioural flop chain of selectable
// length (or a chain output forced low / high) and checks each run against
// results computed arithmetically from the chain length.

module tb_delay_chain_sequencer;

  localparam int DEPTH   = 5;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  localparam int MODE_CHAIN  = 0;
  localparam int MODE_FORCE0 = 1;
  localparam int MODE_FORCE1 = 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             chain_clr;
  logic             chain_din;
  logic             chain_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout_err;
  logic             stuck_err;
  logic [CNT_W-1:0] latency;
  logic             fail_sticky;

  int checkCount;
  int failCount;
  int chainMode;
  logic [4:0]  chainLen;
  logic [3:0]  tapIdx;
  logic [15:0] chainReg;
  logic stickyExp;

  delay_chain_sequencer #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .chain_clr  (chain_clr),
    .chain_din  (chain_din),
    .chain_q    (chain_q),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout_err(timeout_err),
    .stuck_err  (stuck_err),
    .latency    (latency),
    .fail_sticky(fail_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural delay chain: shift register with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chainReg <= '0;
    else if (chain_clr) chainReg <= '0;
    else chainReg <= {chainReg[14:0], chain_din};
  end

  assign tapIdx = 4'(chainLen - 5'd1);

  always_comb begin
    chain_q = chainReg[tapIdx];
    if (chainMode == MODE_FORCE0) chain_q = 1'b0;
    if (chainMode == MODE_FORCE1) chain_q = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".chain_clr"}, chain_clr, 0);
    check({tag, ".chain_din"}, chain_din, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".pass"}, pass, 0);
    check({tag, ".timeout_err"}, timeout_err, 0);
    check({tag, ".stuck_err"}, stuck_err, 0);
    check({tag, ".latency"}, latency, 0);
    check({tag, ".fail_sticky"}, fail_sticky, 0);
  endtask

  // One run: pulse start at a negedge, then watch every following negedge.
  // k counts negedges after the edge that samples start; the expected done
  // position, latency and flags come from the chain length alone.
  task automatic applyStimulus(input int mode, input int len, input int injectAt, input string tag);
    int expDelay, expLat;
    logic expPass, expTo, expStuck;
    int doneK, doneCount;
    chainMode = mode;
    chainLen  = 5'(len);
    if (mode == MODE_FORCE1) begin
      expDelay = 3; expLat = 0; expPass = 0; expTo = 0; expStuck = 1;
    end else if (mode == MODE_FORCE0 || len > TIMEOUT) begin
      expDelay = TIMEOUT + 3; expLat = TIMEOUT; expPass = 0; expTo = 1; expStuck = 0;
    end else begin
      expDelay = len + 3; expLat = len; expPass = (len == DEPTH); expTo = 0; expStuck = 0;
    end
    doneK = 0;
    doneCount = 0;
    start = 1'b1;
    for (int k = 1; k <= expDelay + 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (injectAt != 0 && k == injectAt) start = 1'b1;
      if (injectAt != 0 && k == injectAt + 1) start = 1'b0;
      if (k == 1) begin
        check({tag, ".busyRise"}, busy, 1);
        check({tag, ".clrInClear"}, chain_clr, 1);
        check({tag, ".dinInClear"}, chain_din, 0);
        check({tag, ".passCleared"}, pass, 0);
        check({tag, ".latCleared"}, latency, 0);
      end
      if (k == 2) begin
        check({tag, ".dinInLaunch"}, chain_din, 1);
        check({tag, ".clrInLaunch"}, chain_clr, 0);
      end
      if (done) begin
        doneCount++;
        if (doneK == 0) doneK = k;
      end
    end
    if (!expPass) stickyExp = 1'b1;
    checkOutput(tag, expDelay, expLat, expPass, expTo, expStuck, doneK, doneCount);
  endtask

  task automatic checkOutput(input string tag, input int expDelay, input int expLat,
                             input logic expPass, input logic expTo, input logic expStuck,
                             input int doneK, input int doneCount);
    check({tag, ".doneCycle"}, doneK, expDelay);
    check({tag, ".doneCount"}, doneCount, 1);
    check({tag, ".latency"}, latency, expLat);
    check({tag, ".pass"}, pass, expPass);
    check({tag, ".timeout_err"}, timeout_err, expTo);
    check({tag, ".stuck_err"}, stuck_err, expStuck);
    check({tag, ".busyAfter"}, busy, 0);
`ifdef DCS_STICKY_FAIL_EN
    check({tag, ".fail_sticky"}, fail_sticky, stickyExp);
`else
    check({tag, ".fail_sticky"}, fail_sticky, 0);
`endif
  endtask

  // Directed scenarios followed by randomized runs, all in one sequence.
  initial begin
    int doneCount, lastDone, nDone;
    int dones[3];
    checkCount = 0;
    failCount  = 0;
    stickyExp  = 1'b0;
    chainMode  = MODE_CHAIN;
    chainLen   = 5'd5;
    start      = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(MODE_CHAIN, 5, 0, "exact5");
    applyStimulus(MODE_CHAIN, 6, 0, "long6");
    applyStimulus(MODE_CHAIN, 5, 0, "exact5again");
    applyStimulus(MODE_FORCE0, 5, 0, "force0");
    applyStimulus(MODE_FORCE1, 5, 0, "force1");
    applyStimulus(MODE_CHAIN, 1, 0, "len1");
    applyStimulus(MODE_CHAIN, 15, 0, "len15");
    applyStimulus(MODE_CHAIN, 16, 0, "len16");
    applyStimulus(MODE_CHAIN, 8, 5, "startInMeasure");

    // Reset during MEASURE aborts the run with no done.
    chainMode = MODE_CHAIN;
    chainLen  = 5'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    stickyExp = 1'b0;
    checkResetOutputs("midRunReset");
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    check("midRunReset.noDone", doneCount, 0);
    check("midRunReset.idle", busy, 0);

    // Start held high: done pulses repeat every N+4 cycles.
    chainLen = 5'd4;
    start = 1'b1;
    nDone = 0;
    lastDone = 0;
    for (int k = 1; k <= 40 && nDone < 3; k++) begin
      @(negedge clk);
      if (done) begin
        dones[nDone] = k;
        nDone++;
      end
      lastDone = k;
    end
    start = 1'b0;
    check("heldStart.doneCount", nDone, 3);
    if (nDone == 3) begin
      check("heldStart.period1", dones[1] - dones[0], 8);
      check("heldStart.period2", dones[2] - dones[1], 8);
    end
    check("heldStart.lat", latency, 4);
    repeat (12) @(negedge clk);
    check("heldStart.idle", busy, 0);
    if (!pass) stickyExp = 1'b1;

    // Randomized runs over chain length, forced outputs and stray starts.
    for (int r = 0; r < 16; r++) begin
      int sel, len, inj;
      sel = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 16));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 3)) : 0;
      if (sel == 0) applyStimulus(MODE_FORCE0, len, inj, $sformatf("rnd%0d.f0", r));
      else if (sel == 1) applyStimulus(MODE_FORCE1, len, 0, $sformatf("rnd%0d.f1", r));
      else applyStimulus(MODE_CHAIN, len, inj, $sformatf("rnd%0d.len%0d", r, len));
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
